// File: rtl/setassoc_cache_pkg.sv
// Shared types and helpers for the set-associative cache.
// Field widths derive from the cache geometry parameters.
package setassoc_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL
  } state_t;

  function automatic int fieldW(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic int safeW(input int w);
    return (w > 0) ? w : 1;
  endfunction

  function automatic bit waysOk(input int w);
    return (w == 1) || (w == 2) || (w == 4);
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid, dirty, tag and line storage.
// A single index port serves lookup, fill and word merge.
module cache_way_array
  import setassoc_cache_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS = 4,
  localparam int LINE_W = LINE_WORDS * WORD_W,
  localparam int IDX_W = safeW(fieldW(SETS)),
  localparam int OFF_W = safeW(fieldW(LINE_WORDS)),
  localparam int TAG_W = WORD_W - fieldW(LINE_WORDS) - fieldW(SETS)
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  lookTag,
  output logic              hit,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line,
  input  logic              fillEn,
  input  logic [TAG_W-1:0]  fillTag,
  input  logic [LINE_W-1:0] fillLine,
  input  logic              wordEn,
  input  logic [OFF_W-1:0]  wordOff,
  input  logic [WORD_W-1:0] wordData
);

  logic [SETS-1:0]   validA;
  logic [SETS-1:0]   dirtyA;
  logic [TAG_W-1:0]  tagA  [SETS];
  logic [LINE_W-1:0] dataA [SETS];

  assign valid = validA[idx];
  assign dirty = dirtyA[idx];
  assign tag   = tagA[idx];
  assign line  = dataA[idx];
  assign hit   = valid && (tag == lookTag);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      validA <= '0;
      dirtyA <= '0;
    end else if (fillEn) begin
      validA[idx] <= 1'b1;
      dirtyA[idx] <= 1'b0;
    end else if (wordEn) begin
      dirtyA[idx] <= 1'b1;
    end
  end

  // Payload needs no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (fillEn) begin
      tagA[idx]  <= fillTag;
      dataA[idx] <= fillLine;
    end else if (wordEn) begin
      dataA[idx][wordOff*WORD_W +: WORD_W] <= wordData;
    end
  end

endmodule

// File: rtl/setassoc_cache.sv
// Set-associative write-back, write-allocate cache between a CPU
// port and a fixed-latency line memory.
module setassoc_cache
  import setassoc_cache_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int LINE_WORDS = 4,
  parameter int SETS = 4,
  parameter int WAYS = 2,
  parameter int MEM_LAT = 4
)(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         readC,
  input  logic                         writeC,
  input  logic [WORD_W-1:0]            addressC,
  input  logic [WORD_W-1:0]            wdataC,
  output logic [WORD_W-1:0]            rdataC,
  output logic                         ready,
  output logic                         readM,
  output logic                         writeM,
  output logic [WORD_W-1:0]            addressM,
  input  logic [LINE_WORDS*WORD_W-1:0] dataM_in,
  output logic [LINE_WORDS*WORD_W-1:0] dataM_out,
  output logic [15:0]                  hit_cnt,
  output logic [15:0]                  miss_cnt
);

  localparam int LINE_W = LINE_WORDS * WORD_W;
  localparam int OFF_N  = fieldW(LINE_WORDS);
  localparam int IDX_N  = fieldW(SETS);
  localparam int OFF_W  = safeW(OFF_N);
  localparam int IDX_W  = safeW(IDX_N);
  localparam int TAG_W  = WORD_W - OFF_N - IDX_N;
  localparam int PTR_W  = safeW(fieldW(WAYS));
  localparam int CNT_W  = $clog2(MEM_LAT) + 1;

  if (!waysOk(WAYS)) begin : gBadWays
    $error("setassoc_cache: WAYS must be 1, 2 or 4");
  end

  function automatic logic [IDX_W-1:0] idxOf(input logic [WORD_W-1:0] a);
    return IDX_W'((a >> OFF_N) & WORD_W'(SETS - 1));
  endfunction

  function automatic logic [TAG_W-1:0] tagOf(input logic [WORD_W-1:0] a);
    return TAG_W'(a >> (OFF_N + IDX_N));
  endfunction

  function automatic logic [OFF_W-1:0] offOf(input logic [WORD_W-1:0] a);
    return OFF_W'(a & WORD_W'(LINE_WORDS - 1));
  endfunction

  function automatic logic [WORD_W-1:0] lineAddr(
    input logic [TAG_W-1:0] t,
    input logic [IDX_W-1:0] i
  );
    return (WORD_W'(t) << (OFF_N + IDX_N)) | (WORD_W'(i) << OFF_N);
  endfunction

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   addrL;
  logic [WORD_W-1:0]   wdataL;
  logic                writeL;
  logic [PTR_W-1:0]    vicL;
  logic                anyInvL;
  logic [PTR_W-1:0]    ptr [SETS];

  logic [WAYS-1:0]     hitV;
  logic [WAYS-1:0]     validV;
  logic [WAYS-1:0]     dirtyV;
  logic [TAG_W-1:0]    tagV  [WAYS];
  logic [LINE_W-1:0]   lineV [WAYS];

  logic [IDX_W-1:0]    lkIdx;
  logic [LINE_W-1:0]   hitLine;
  logic [LINE_W-1:0]   fillLine;
  logic [PTR_W-1:0]    victim;
  logic                anyInv;
  logic                req;
  logic                fillGo;
  logic                wordGo;

  assign req    = readC | writeC;
  assign lkIdx  = (state == IDLE) ? idxOf(addressC) : idxOf(addrL);
  assign ready  = (state == IDLE) && req && (|hitV);
  assign rdataC = ready ? hitLine[offOf(addressC)*WORD_W +: WORD_W] : '0;
  assign fillGo = (state == FILL) && (cnt == '0);
  assign wordGo = (state == IDLE) && writeC && (|hitV);

  always_comb begin
    hitLine = '0;
    for (int w = 0; w < WAYS; w++)
      if (hitV[w]) hitLine = hitLine | lineV[w];
  end

  // Lowest invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    victim = ptr[idxOf(addressC)];
    anyInv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!validV[w]) begin
        victim = PTR_W'(w);
        anyInv = 1'b1;
      end
  end

  always_comb begin
    fillLine = dataM_in;
    if (writeL) fillLine[offOf(addrL)*WORD_W +: WORD_W] = wdataL;
  end

  for (genvar w = 0; w < WAYS; w++) begin : gWay
    cache_way_array #(
      .WORD_W(WORD_W),
      .LINE_WORDS(LINE_WORDS),
      .SETS(SETS)
    ) uWay (
      .clk(clk),
      .reset_n(reset_n),
      .idx(lkIdx),
      .lookTag(tagOf(addressC)),
      .hit(hitV[w]),
      .valid(validV[w]),
      .dirty(dirtyV[w]),
      .tag(tagV[w]),
      .line(lineV[w]),
      .fillEn(fillGo && (vicL == PTR_W'(w))),
      .fillTag(tagOf(addrL)),
      .fillLine(fillLine),
      .wordEn(wordGo && hitV[w]),
      .wordOff(offOf(addressC)),
      .wordData(wdataC)
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addrL     <= '0;
      wdataL    <= '0;
      writeL    <= 1'b0;
      vicL      <= '0;
      anyInvL   <= 1'b0;
      readM     <= 1'b0;
      writeM    <= 1'b0;
      addressM  <= '0;
      dataM_out <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ready) begin
            hit_cnt <= satInc(hit_cnt);
          end else if (req) begin
            addrL    <= addressC;
            writeL   <= writeC;
            wdataL   <= wdataC;
            vicL     <= victim;
            anyInvL  <= anyInv;
            miss_cnt <= satInc(miss_cnt);
            cnt      <= CNT_W'(MEM_LAT - 1);
            if (validV[victim] && dirtyV[victim]) begin
              state     <= WB;
              writeM    <= 1'b1;
              addressM  <= lineAddr(tagV[victim], idxOf(addressC));
              dataM_out <= lineV[victim];
            end else begin
              state    <= FILL;
              readM    <= 1'b1;
              addressM <= lineAddr(tagOf(addressC), idxOf(addressC));
            end
          end
        end
        WB: begin
          if (cnt == '0) begin
            state     <= FILL;
            writeM    <= 1'b0;
            readM     <= 1'b1;
            dataM_out <= '0;
            addressM  <= lineAddr(tagOf(addrL), idxOf(addrL));
            cnt       <= CNT_W'(MEM_LAT - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FILL: begin
          if (cnt == '0) begin
            state    <= IDLE;
            readM    <= 1'b0;
            addressM <= '0;
            if (!anyInvL)
              ptr[idxOf(addrL)] <= (vicL == PTR_W'(WAYS - 1)) ? '0 : vicL + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_setassoc_cache.sv
// Directed vectors on the default cache plus a random reference-model
// sweep over two alternative geometries.
module tb_setassoc_cache;

  logic        clk = 1'b0;
  logic        resetN;
  logic        readC, writeC;
  logic [15:0] addressC, wdataC, rdataC, addressM;
  logic        ready, readM, writeM;
  logic [63:0] dataM_in, dataM_out;
  logic [15:0] hitCnt, missCnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  setassoc_cache dut (
    .clk(clk), .reset_n(resetN),
    .readC(readC), .writeC(writeC),
    .addressC(addressC), .wdataC(wdataC),
    .rdataC(rdataC), .ready(ready),
    .readM(readM), .writeM(writeM), .addressM(addressM),
    .dataM_in(dataM_in), .dataM_out(dataM_out),
    .hit_cnt(hitCnt), .miss_cnt(missCnt)
  );

  function automatic logic [63:0] defLine(input logic [15:0] base, input logic [15:0] a);
    logic [63:0] l;
    for (int k = 0; k < 4; k++)
      l[k*16 +: 16] = base + {a[15:2], 2'b00} + 16'(k);
    return l;
  endfunction

  // Line memory behind the default cache; untouched words read base+address.
  logic [63:0] mainMem [256];
  bit          mainW   [256];
  always @(posedge clk)
    if (writeM) begin
      mainMem[addressM[9:2]] <= dataM_out;
      mainW[addressM[9:2]]   <= 1'b1;
    end
  assign dataM_in = mainW[addressM[9:2]] ? mainMem[addressM[9:2]]
                                         : defLine(16'hA000, addressM);

  // Sweep instances: 0 = 4 ways/8 sets/lat 6, 1 = 1 way/1 set/lat 1.
  logic        rdS [2], wrS [2], readyS [2], rmS [2], wmS [2];
  logic [15:0] adS [2], wdS [2], rdataS [2], amS [2], hcS [2], mcS [2];
  logic [63:0] dinS [2], doutS [2];

  setassoc_cache #(.WAYS(4), .SETS(8), .MEM_LAT(6)) dutA (
    .clk(clk), .reset_n(resetN),
    .readC(rdS[0]), .writeC(wrS[0]),
    .addressC(adS[0]), .wdataC(wdS[0]),
    .rdataC(rdataS[0]), .ready(readyS[0]),
    .readM(rmS[0]), .writeM(wmS[0]), .addressM(amS[0]),
    .dataM_in(dinS[0]), .dataM_out(doutS[0]),
    .hit_cnt(hcS[0]), .miss_cnt(mcS[0])
  );

  setassoc_cache #(.WAYS(1), .SETS(1), .MEM_LAT(1)) dutB (
    .clk(clk), .reset_n(resetN),
    .readC(rdS[1]), .writeC(wrS[1]),
    .addressC(adS[1]), .wdataC(wdS[1]),
    .rdataC(rdataS[1]), .ready(readyS[1]),
    .readM(rmS[1]), .writeM(wmS[1]), .addressM(amS[1]),
    .dataM_in(dinS[1]), .dataM_out(doutS[1]),
    .hit_cnt(hcS[1]), .miss_cnt(mcS[1])
  );

  for (genvar g = 0; g < 2; g++) begin : gMem
    logic [63:0] lm [32];
    bit          lw [32];
    always @(posedge clk)
      if (wmS[g]) begin
        lm[amS[g][6:2]] <= doutS[g];
        lw[amS[g][6:2]] <= 1'b1;
      end
    assign dinS[g] = lw[amS[g][6:2]] ? lm[amS[g][6:2]] : defLine(16'h5000, amS[g]);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    int          lat;
    logic [15:0] q;
    int          wc;
    logic [15:0] w0;
    logic [15:0] wa;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] d,
                              input int lat, input logic [15:0] q,
                              input int wc, input logic [15:0] w0,
                              input logic [15:0] wa);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.lat = lat;
    v.q = q; v.wc = wc; v.w0 = w0; v.wa = wa;
    return v;
  endfunction

  int          rdCyc, wrCyc;
  logic [15:0] rAddr, wAddr, wWord0;
  logic        overlap;

  task automatic access(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] q);
    @(posedge clk); #1;
    readC = rd; writeC = wr; addressC = a; wdataC = d;
    rdCyc = 0; wrCyc = 0; rAddr = '0; wAddr = '0; wWord0 = '0;
    overlap = 1'b0; lat = 0;
    @(negedge clk);
    while (!ready && lat < 40) begin
      @(negedge clk);
      lat++;
      if (readM) begin rdCyc++; rAddr = addressM; end
      if (writeM) begin wrCyc++; wAddr = addressM; wWord0 = dataM_out[15:0]; end
      if (readM && writeM) overlap = 1'b1;
    end
    q = rdataC;
    @(posedge clk); #1;
    readC = 1'b0; writeC = 1'b0;
  endtask

  task automatic sweep(input int g);
    logic [15:0] refm [128];
    int          a, to;
    logic        w;
    logic [15:0] d;
    for (int i = 0; i < 128; i++) refm[i] = 16'h5000 + 16'(i);
    for (int r = 0; r < 1000; r++) begin
      a = $urandom_range(0, 127);
      w = ($urandom_range(0, 2) == 0);
      d = 16'($urandom);
      @(posedge clk); #1;
      rdS[g] = !w; wrS[g] = w; adS[g] = 16'(a); wdS[g] = d;
      to = 0;
      @(negedge clk);
      while (!readyS[g] && to < 40) begin
        @(negedge clk);
        to++;
      end
      chk($sformatf("sweep%0d_ready r%0d", g, r), readyS[g], 1'b1);
      if (w) refm[a] = d;
      else chk($sformatf("sweep%0d_rdata a=%h", g, a), rdataS[g], refm[a]);
      @(posedge clk); #1;
      rdS[g] = 1'b0; wrS[g] = 1'b0;
    end
  endtask

  vec_t        tab [20];
  int          lat, expHit, expMiss;
  logic [15:0] q;

  initial begin
    resetN = 1'b0; readC = 1'b0; writeC = 1'b0;
    addressC = '0; wdataC = '0;
    for (int g = 0; g < 2; g++) begin
      rdS[g] = 1'b0; wrS[g] = 1'b0; adS[g] = '0; wdS[g] = '0;
    end

    tab[0]  = mk(1, 0, 16'h0005, 16'h0000, 5, 16'hA005, 0, 16'h0000, 16'h0000);
    tab[1]  = mk(1, 0, 16'h0006, 16'h0000, 0, 16'hA006, 0, 16'h0000, 16'h0000);
    tab[2]  = mk(0, 1, 16'h0004, 16'hBEEF, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    tab[3]  = mk(1, 0, 16'h0014, 16'h0000, 5, 16'hA014, 0, 16'h0000, 16'h0000);
    tab[4]  = mk(1, 0, 16'h0024, 16'h0000, 9, 16'hA024, 4, 16'hBEEF, 16'h0004);
    tab[5]  = mk(1, 0, 16'h0004, 16'h0000, 5, 16'hBEEF, 0, 16'h0000, 16'h0000);
    tab[6]  = mk(1, 0, 16'h0000, 16'h0000, 5, 16'hA000, 0, 16'h0000, 16'h0000);
    tab[7]  = mk(1, 0, 16'h0040, 16'h0000, 5, 16'hA040, 0, 16'h0000, 16'h0000);
    tab[8]  = mk(1, 0, 16'h0080, 16'h0000, 5, 16'hA080, 0, 16'h0000, 16'h0000);
    tab[9]  = mk(1, 0, 16'h00C0, 16'h0000, 5, 16'hA0C0, 0, 16'h0000, 16'h0000);
    tab[10] = mk(1, 0, 16'h0080, 16'h0000, 0, 16'hA080, 0, 16'h0000, 16'h0000);
    tab[11] = mk(1, 0, 16'h00C0, 16'h0000, 0, 16'hA0C0, 0, 16'h0000, 16'h0000);
    tab[12] = mk(1, 0, 16'h0040, 16'h0000, 5, 16'hA040, 0, 16'h0000, 16'h0000);
    tab[13] = mk(0, 1, 16'h0030, 16'h1234, 5, 16'h0000, 0, 16'h0000, 16'h0000);
    tab[14] = mk(1, 0, 16'h0030, 16'h0000, 0, 16'h1234, 0, 16'h0000, 16'h0000);
    tab[15] = mk(1, 1, 16'h0031, 16'h5555, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    tab[16] = mk(1, 0, 16'h0031, 16'h0000, 0, 16'h5555, 0, 16'h0000, 16'h0000);
    tab[17] = mk(1, 0, 16'h0070, 16'h0000, 5, 16'hA070, 0, 16'h0000, 16'h0000);
    tab[18] = mk(1, 0, 16'h00B0, 16'h0000, 9, 16'hA0B0, 4, 16'h1234, 16'h0030);
    tab[19] = mk(1, 0, 16'h0031, 16'h0000, 5, 16'h5555, 0, 16'h0000, 16'h0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_readM", readM, 1'b0);
    chk("rst_writeM", writeM, 1'b0);
    chk("rst_addressM", addressM, 16'h0000);
    chk("rst_dataM_out", dataM_out, 64'h0);
    chk("rst_rdataC", rdataC, 16'h0000);
    chk("rst_hit_cnt", hitCnt, 16'd0);
    chk("rst_miss_cnt", missCnt, 16'd0);
    @(posedge clk); #1;
    resetN = 1'b1;

    expHit = 0;
    expMiss = 0;
    for (int i = 0; i < 20; i++) begin
      access(tab[i].rd, tab[i].wr, tab[i].a, tab[i].d, lat, q);
      expHit++;
      if (tab[i].lat > 0) expMiss++;
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(tab[i].lat));
      if (tab[i].rd && !tab[i].wr)
        chk($sformatf("v%0d_rdata", i), q, tab[i].q);
      chk($sformatf("v%0d_readM_cycles", i), 64'(rdCyc), 64'((tab[i].lat > 0) ? 4 : 0));
      chk($sformatf("v%0d_writeM_cycles", i), 64'(wrCyc), 64'(tab[i].wc));
      chk($sformatf("v%0d_overlap", i), overlap, 1'b0);
      if (tab[i].lat > 0)
        chk($sformatf("v%0d_fill_addr", i), rAddr, tab[i].a & 16'hFFFC);
      if (tab[i].wc > 0) begin
        chk($sformatf("v%0d_wb_addr", i), wAddr, tab[i].wa);
        chk($sformatf("v%0d_wb_word0", i), wWord0, tab[i].w0);
      end
    end
    chk("tab_hit_cnt", hitCnt, 16'(expHit));
    chk("tab_miss_cnt", missCnt, 16'(expMiss));

    // No request: nothing may move.
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", ready, 1'b0);
      chk("idle_strobes", {readM, writeM}, 2'b00);
    end
    chk("idle_hit_cnt", hitCnt, 16'(expHit));
    chk("idle_miss_cnt", missCnt, 16'(expMiss));

    // Reset during the second FILL cycle.
    @(posedge clk); #1;
    readC = 1'b1; addressC = 16'h0108;
    @(negedge clk);
    chk("midfill_req_ready", ready, 1'b0);
    @(negedge clk);
    chk("midfill_readM_c1", readM, 1'b1);
    @(posedge clk); #1;
    resetN = 1'b0; readC = 1'b0;
    @(posedge clk); #1;
    chk("midfill_readM_after_rst", readM, 1'b0);
    chk("midfill_addressM_after_rst", addressM, 16'h0000);
    chk("midfill_miss_cnt_after_rst", missCnt, 16'd0);
    resetN = 1'b1;
    access(1'b1, 1'b0, 16'h0108, 16'h0000, lat, q);
    chk("postrst_latency", 64'(lat), 64'd5);
    chk("postrst_rdata", q, 16'hA108);
    chk("postrst_readM_cycles", 64'(rdCyc), 64'd4);
    chk("postrst_hit_cnt", hitCnt, 16'd1);
    chk("postrst_miss_cnt", missCnt, 16'd1);

    sweep(0);
    sweep(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
